iob_cache_line_fetch: RTL and testbench



---
 rtl/iob_cache_line_fetch.sv | 131 +++++++++++++
 tb/tb_iob_cache_line_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_line_fetch.sv
// Cache line refill engine: fetches one cache line from the back-end memory
// as NBEATS back-end beats, optionally starting at the beat that holds the
// missed word (wrap-around). Each beat is forwarded to the line RAM on the
// cycle it is acknowledged, and the critical beat raises a one-cycle
// early-restart pulse.
module iob_cache_line_fetch #(
    parameter int FE_ADDR_W      = 32,
    parameter int FE_DATA_W      = 32,
    parameter int BE_ADDR_W      = 32,
    parameter int BE_DATA_W      = 32,
    parameter int WORD_OFFSET_W  = 2,
    parameter int CRITICAL_FIRST = 0,
    localparam int BE_NBYTES_W   = $clog2(BE_DATA_W / 8),
    localparam int LINE2BE_W     = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
    localparam int NBEATS        = 2 ** LINE2BE_W,
    localparam int PTR_W         = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             replace_valid_i,
    input  logic [FE_ADDR_W-1:BE_NBYTES_W]   replace_addr_i,
    output logic                             replace_o,
    output logic                             read_valid_o,
    output logic [PTR_W-1:0]                 read_addr_o,
    output logic [BE_DATA_W-1:0]             read_rdata_o,
    output logic                             crit_valid_o,
    output logic [BE_ADDR_W-1:0]             be_addr_o,
    output logic                             be_valid_o,
    input  logic                             be_ack_i,
    input  logic [BE_DATA_W-1:0]             be_rdata_i
);

    // Number of address bits above the beat index (the line tag).
    localparam int LINE_W = FE_ADDR_W - BE_NBYTES_W - LINE2BE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_reg;
    logic                replace_reg;
    logic                be_valid_reg;
    logic [LINE_W-1:0]   line_reg;
    logic [PTR_W-1:0]    beat_ptr_reg;
    logic [PTR_W-1:0]    beat_cnt_reg;
    logic [PTR_W-1:0]    crit_beat_reg;

    logic [LINE_W-1:0]    line_in;
    logic [PTR_W-1:0]     crit_in;
    logic [PTR_W-1:0]     beat_ptr_next;
    logic                 ack_hit;
    logic                 last_beat;
    logic [FE_ADDR_W-1:0] addr_full;

    assign line_in = replace_addr_i[FE_ADDR_W-1:BE_NBYTES_W+LINE2BE_W];

    // With a single beat per line there is no beat index: the pointer stays 0.
    generate
        if (LINE2BE_W > 0) begin : g_multi_beat
            assign crit_in       = replace_addr_i[BE_NBYTES_W+LINE2BE_W-1:BE_NBYTES_W];
            assign beat_ptr_next = beat_ptr_reg + PTR_W'(1);
        end else begin : g_single_beat
            assign crit_in       = '0;
            assign beat_ptr_next = '0;
        end
    endgenerate

    assign ack_hit   = (state_reg == FETCH) && be_ack_i;
    assign last_beat = (beat_cnt_reg == PTR_W'(NBEATS - 1));

    // Byte address of the current beat; beat_ptr is always 0 for single-beat lines.
    assign addr_full = (FE_ADDR_W'(line_reg) << (BE_NBYTES_W + LINE2BE_W))
                     | (FE_ADDR_W'(beat_ptr_reg) << BE_NBYTES_W);

    assign be_addr_o    = BE_ADDR_W'(addr_full);
    assign be_valid_o   = be_valid_reg;
    assign replace_o    = replace_reg;
    assign read_valid_o = ack_hit;
    assign read_addr_o  = beat_ptr_reg;
    assign read_rdata_o = be_rdata_i;
    assign crit_valid_o = ack_hit && (beat_ptr_reg == crit_beat_reg);

    // Refill FSM: accept a request, walk the beats on each ack, one DONE cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            replace_reg   <= 1'b0;
            be_valid_reg  <= 1'b0;
            line_reg      <= '0;
            beat_ptr_reg  <= '0;
            beat_cnt_reg  <= '0;
            crit_beat_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (replace_valid_i) begin
                        line_reg      <= line_in;
                        crit_beat_reg <= crit_in;
                        beat_ptr_reg  <= (CRITICAL_FIRST != 0) ? crit_in : '0;
                        beat_cnt_reg  <= '0;
                        state_reg     <= FETCH;
                        replace_reg   <= 1'b1;
                        be_valid_reg  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (be_ack_i) begin
                        beat_ptr_reg <= beat_ptr_next;
                        beat_cnt_reg <= beat_cnt_reg + PTR_W'(1);
                        if (last_beat) begin
                            state_reg    <= DONE;
                            be_valid_reg <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_reg   <= IDLE;
                    replace_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    replace_reg  <= 1'b0;
                    be_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cache_line_fetch.sv
// Directed bench for iob_cache_line_fetch: a normal-order and a
// critical-first instance share stimulus, plus a one-beat-per-line instance.
module tb_iob_cache_line_fetch;

    logic clk = 1'b0;
    logic rst;
    logic rv;
    logic ack;
    logic [29:0]  addr;
    logic [31:0]  rdata;
    logic [27:0]  w_addr;
    logic [127:0] w_rdata;

    logic        c0_replace, c0_read_valid, c0_crit, c0_be_valid;
    logic [1:0]  c0_read_addr;
    logic [31:0] c0_read_rdata, c0_be_addr;
    logic        c1_replace, c1_read_valid, c1_crit, c1_be_valid;
    logic [1:0]  c1_read_addr;
    logic [31:0] c1_read_rdata, c1_be_addr;
    logic         w_replace, w_read_valid, w_crit, w_be_valid;
    logic [0:0]   w_read_addr;
    logic [127:0] w_read_rdata;
    logic [31:0]  w_be_addr;

    int errors = 0;
    int checks = 0;
    int rep_cnt;
    int pulses;

    always #5 clk = ~clk;

    iob_cache_line_fetch #(.CRITICAL_FIRST(0)) u_c0 (
        .clk_i(clk), .reset_i(rst), .replace_valid_i(rv), .replace_addr_i(addr),
        .replace_o(c0_replace), .read_valid_o(c0_read_valid), .read_addr_o(c0_read_addr),
        .read_rdata_o(c0_read_rdata), .crit_valid_o(c0_crit), .be_addr_o(c0_be_addr),
        .be_valid_o(c0_be_valid), .be_ack_i(ack), .be_rdata_i(rdata));

    iob_cache_line_fetch #(.CRITICAL_FIRST(1)) u_c1 (
        .clk_i(clk), .reset_i(rst), .replace_valid_i(rv), .replace_addr_i(addr),
        .replace_o(c1_replace), .read_valid_o(c1_read_valid), .read_addr_o(c1_read_addr),
        .read_rdata_o(c1_read_rdata), .crit_valid_o(c1_crit), .be_addr_o(c1_be_addr),
        .be_valid_o(c1_be_valid), .be_ack_i(ack), .be_rdata_i(rdata));

    iob_cache_line_fetch #(.BE_DATA_W(128), .FE_DATA_W(32), .WORD_OFFSET_W(2)) u_w (
        .clk_i(clk), .reset_i(rst), .replace_valid_i(rv), .replace_addr_i(w_addr),
        .replace_o(w_replace), .read_valid_o(w_read_valid), .read_addr_o(w_read_addr),
        .read_rdata_o(w_read_rdata), .crit_valid_o(w_crit), .be_addr_o(w_be_addr),
        .be_valid_o(w_be_valid), .be_ack_i(ack), .be_rdata_i(w_rdata));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rv = 1'b0; ack = 1'b1; addr = '0; rdata = '0;
        w_addr = '0; w_rdata = '0;
        #3;
        check("rst_replace", c0_replace, 1'b0);
        check("rst_be_valid", c0_be_valid, 1'b0);
        check("rst_read_valid", c0_read_valid, 1'b0);
        check("rst_crit", c0_crit, 1'b0);
        check("rst_read_addr", c0_read_addr, 2'd0);
        check("rst_be_addr", c0_be_addr, 32'h0);
        check("rst_w_be_valid", w_be_valid, 1'b0);
        ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic refill at 0x1008, ack every cycle, all three instances
        rv = 1'b1; addr = 30'h402; w_addr = 28'h100;
        @(negedge clk);
        check("s1_idle_replace", c0_replace, 1'b0);
        check("s1_idle_be_valid", c0_be_valid, 1'b0);
        tick();
        rv = 1'b0; ack = 1'b1; rep_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            rdata = 32'hA0 + k;
            w_rdata = {96'h0, 32'hC0 + k};
            @(negedge clk);
            if (c0_replace) rep_cnt++;
            check($sformatf("s1_c0_be_addr%0d", k), c0_be_addr, 32'h1000 + 4 * k);
            check($sformatf("s1_c0_read_addr%0d", k), c0_read_addr, k);
            check($sformatf("s1_c0_read_valid%0d", k), c0_read_valid, 1'b1);
            check($sformatf("s1_c0_rdata%0d", k), c0_read_rdata, 32'hA0 + k);
            check($sformatf("s1_c0_crit%0d", k), c0_crit, (k == 2));
            check($sformatf("s1_c1_be_addr%0d", k), c1_be_addr, 32'h1000 + 4 * ((k + 2) % 4));
            check($sformatf("s1_c1_read_addr%0d", k), c1_read_addr, (k + 2) % 4);
            check($sformatf("s1_c1_crit%0d", k), c1_crit, (k == 0));
            if (k == 0) begin
                check("s1_w_be_addr", w_be_addr, 32'h1000);
                check("s1_w_read_valid", w_read_valid, 1'b1);
                check("s1_w_crit", w_crit, 1'b1);
                check("s1_w_read_addr", w_read_addr, 1'b0);
                check("s1_w_rdata", w_read_rdata, 128'hC0);
            end else if (k == 1) begin
                check("s1_w_done_replace", w_replace, 1'b1);
                check("s1_w_done_be_valid", w_be_valid, 1'b0);
                check("s1_w_done_read_valid", w_read_valid, 1'b0);
            end else if (k == 2) begin
                check("s1_w_idle_replace", w_replace, 1'b0);
            end
            tick();
        end
        @(negedge clk);
        if (c0_replace) rep_cnt++;
        check("s1_done_replace", c0_replace, 1'b1);
        check("s1_done_be_valid", c0_be_valid, 1'b0);
        check("s1_done_read_valid", c0_read_valid, 1'b0);
        check("s1_done_crit", c0_crit, 1'b0);
        check("s1_c1_done_be_valid", c1_be_valid, 1'b0);
        tick();
        ack = 1'b0;
        @(negedge clk);
        if (c0_replace) rep_cnt++;
        check("s1_replace_cycles", rep_cnt, 5);
        tick();

        // Slow back-end: ack every third cycle at 0x3000
        rv = 1'b1; addr = 30'hC00;
        tick();
        rv = 1'b0; pulses = 0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                ack = (w == 2);
                rdata = 32'hB0 + k;
                @(negedge clk);
                if (c0_read_valid) pulses++;
                check($sformatf("s2_be_valid%0d_%0d", k, w), c0_be_valid, 1'b1);
                check($sformatf("s2_be_addr%0d_%0d", k, w), c0_be_addr, 32'h3000 + 4 * k);
                check($sformatf("s2_read_valid%0d_%0d", k, w), c0_read_valid, (w == 2));
                tick();
            end
        end
        ack = 1'b0;
        @(negedge clk);
        if (c0_read_valid) pulses++;
        check("s2_done_be_valid", c0_be_valid, 1'b0);
        check("s2_pulses", pulses, 4);
        tick(); tick();

        // replace_valid held high: ignored in FETCH/DONE, re-accepted in IDLE
        rv = 1'b1; addr = 30'h402;
        tick();
        addr = 30'h800; ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("s3_be_addr%0d", k), c0_be_addr, 32'h1000 + 4 * k);
            tick();
        end
        @(negedge clk);
        check("s3_done_replace", c0_replace, 1'b1);
        check("s3_done_be_valid", c0_be_valid, 1'b0);
        tick();
        @(negedge clk);
        check("s3_idle_replace", c0_replace, 1'b0);
        check("s3_idle_be_valid", c0_be_valid, 1'b0);
        tick();
        rv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("s3_next_be_valid%0d", k), c0_be_valid, 1'b1);
            check($sformatf("s3_next_be_addr%0d", k), c0_be_addr, 32'h2000 + 4 * k);
            tick();
        end
        ack = 1'b0;
        tick(); tick();

        // Reset after two acks abandons the refill
        rv = 1'b1; addr = 30'h402;
        tick();
        rv = 1'b0; ack = 1'b1;
        tick(); tick();
        ack = 1'b0; rst = 1'b1;
        #1;
        check("s4_rst_be_valid", c0_be_valid, 1'b0);
        check("s4_rst_replace", c0_replace, 1'b0);
        check("s4_rst_be_addr", c0_be_addr, 32'h0);
        check("s4_rst_read_addr", c0_read_addr, 2'd0);
        check("s4_rst_c1_be_valid", c1_be_valid, 1'b0);
        tick();
        rst = 1'b0;
        rv = 1'b1; addr = 30'h801;
        @(negedge clk);
        check("s4_idle_be_valid", c0_be_valid, 1'b0);
        tick();
        rv = 1'b0; ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("s4_c0_be_addr%0d", k), c0_be_addr, 32'h2000 + 4 * k);
            check($sformatf("s4_c0_crit%0d", k), c0_crit, (k == 1));
            check($sformatf("s4_c1_be_addr%0d", k), c1_be_addr, 32'h2000 + 4 * ((k + 1) % 4));
            check($sformatf("s4_c1_read_addr%0d", k), c1_read_addr, (k + 1) % 4);
            check($sformatf("s4_c1_crit%0d", k), c1_crit, (k == 0));
            tick();
        end
        @(negedge clk);
        check("s4_done_replace", c0_replace, 1'b1);
        check("s4_done_read_valid", c0_read_valid, 1'b0);
        ack = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
